// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles every signal between the two result producers (EX, SLB), the
//   ROB control lines and the common data bus broadcast.
//   Modports:
//     master : the environment side (drives rdy/iclr and producer inputs,
//              observes full flags and the CDB broadcast)
//     slave  : the arbiter side
//   Signals:
//     rdy, iclr                          global enable, ROB flush
//     iEX_en/nick/dt/ac/j_pc, oEX_full   EX producer port
//     iSLB_en/nick/dt, oSLB_full         SLB producer port
//     oCDB_en/nick/dt/ac/j_pc/src        registered broadcast
interface cdb_arbiter_if #(
    parameter int NICK_W = 5,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              iclr;

    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [DATA_W-1:0] iEX_dt;
    logic              iEX_ac;
    logic [DATA_W-1:0] iEX_j_pc;
    logic              oEX_full;

    logic              iSLB_en;
    logic [NICK_W-1:0] iSLB_nick;
    logic [DATA_W-1:0] iSLB_dt;
    logic              oSLB_full;

    logic              oCDB_en;
    logic [NICK_W-1:0] oCDB_nick;
    logic [DATA_W-1:0] oCDB_dt;
    logic              oCDB_ac;
    logic [DATA_W-1:0] oCDB_j_pc;
    logic              oCDB_src;

    modport master (
        output rdy, iclr,
        output iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
        output iSLB_en, iSLB_nick, iSLB_dt,
        input  oEX_full, oSLB_full,
        input  oCDB_en, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oCDB_src
    );

    modport slave (
        input  rdy, iclr,
        input  iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
        input  iSLB_en, iSLB_nick, iSLB_dt,
        output oEX_full, oSLB_full,
        output oCDB_en, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oCDB_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Schedules the common data bus. EX and SLB results each land in a private
//   FIFO; every cycle at most one head is broadcast, round-robin between the
//   two sources. A ROB flush (iclr) discards everything queued.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  cdb_arbiter_if.slave (producer inputs, full flags, CDB outputs)
module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int NICK_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    cdb_arbiter_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic SRC_EX  = 1'b0;
    localparam logic SRC_SLB = 1'b1;

    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
        logic              ac;
        logic [DATA_W-1:0] j_pc;
    } entry_t;

    // Index 0 = EX, index 1 = SLB throughout.
    entry_t [1:0] in_entry;
    entry_t [1:0] head;
    logic   [1:0] in_en;
    logic   [1:0] valid;
    logic   [1:0] full;
    logic   [1:0] push;
    logic   [1:0] pop;

    logic   advance;
    logic   grant_any;
    logic   grant_src;
    logic   last_grant_reg;

    entry_t cdb_reg;
    logic   cdb_en_reg;
    logic   cdb_src_reg;

    // SLB results carry no branch information, so those fields are forced to 0.
    assign in_en[0]    = bus.iEX_en;
    assign in_entry[0] = '{nick: bus.iEX_nick, dt: bus.iEX_dt,
                           ac: bus.iEX_ac, j_pc: bus.iEX_j_pc};
    assign in_en[1]    = bus.iSLB_en;
    assign in_entry[1] = '{nick: bus.iSLB_nick, dt: bus.iSLB_dt,
                           ac: 1'b0, j_pc: '0};

    // Flush outranks the enable; neither queue moves unless both allow it.
    assign advance = bus.rdy && !bus.iclr;

    // Grant looks only at FIFO state before this edge, so nothing bypasses
    // the queue: a fresh entry needs at least one more edge to be broadcast.
    always_comb begin
        grant_any = 1'b0;
        grant_src = SRC_EX;
        if (valid[0] && valid[1]) begin
            grant_any = 1'b1;
            grant_src = ~last_grant_reg;
        end else if (valid[0]) begin
            grant_any = 1'b1;
            grant_src = SRC_EX;
        end else if (valid[1]) begin
            grant_any = 1'b1;
            grant_src = SRC_SLB;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_fifo
            entry_t            mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;

            // Full ignores a same-edge pop, so a full FIFO refuses input
            // even while its head is being granted. Nick 0 means "no tag".
            assign push[gi]  = advance && in_en[gi] && !full[gi]
                               && (in_entry[gi].nick != '0);
            assign pop[gi]   = advance && grant_any && (grant_src == 1'(gi));
            assign valid[gi] = (count_reg != '0);
            assign full[gi]  = (count_reg == CNT_W'(DEPTH));
            assign head[gi]  = mem[rd_ptr_reg];

            // Storage needs no reset: a slot is only read after being written.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_entry[gi];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (bus.iclr) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    // Pointer width is log2(DEPTH), so increments wrap for free.
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Broadcast registers. Only oCDB_en is cleared on flush/freeze; the
    // payload holds its last value so downstream sees no spurious change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_reg        <= '0;
            cdb_en_reg     <= 1'b0;
            cdb_src_reg    <= SRC_EX;
            last_grant_reg <= SRC_SLB;   // EX wins the first tie after reset
        end else if (bus.iclr || !bus.rdy) begin
            cdb_en_reg     <= 1'b0;
        end else if (grant_any) begin
            cdb_reg        <= head[grant_src];
            cdb_en_reg     <= 1'b1;
            cdb_src_reg    <= grant_src;
            last_grant_reg <= grant_src;
        end else begin
            cdb_en_reg     <= 1'b0;
        end
    end

    assign bus.oEX_full  = full[0];
    assign bus.oSLB_full = full[1];
    assign bus.oCDB_en   = cdb_en_reg;
    assign bus.oCDB_nick = cdb_reg.nick;
    assign bus.oCDB_dt   = cdb_reg.dt;
    assign bus.oCDB_ac   = cdb_reg.ac;
    assign bus.oCDB_j_pc = cdb_reg.j_pc;
    assign bus.oCDB_src  = cdb_src_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed stimulus with a scoreboard: expected broadcasts are queued in
//   the order they must appear, and a negedge monitor pops and compares each
//   time oCDB_en is high. Cycle-exact properties (latency, pulse length,
//   full flags, flush and reset effects) are checked inline.
module tb_cdb_arbiter;
    typedef struct packed {
        logic [4:0]  nick;
        logic [31:0] dt;
        logic        ac;
        logic [31:0] j_pc;
        logic        src;
    } bc_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bc_t  sb[$];
    bc_t  mon_exp;
    bc_t  mon_act;

    cdb_arbiter_if #(.NICK_W(5), .DATA_W(32)) bus ();

    cdb_arbiter #(.DEPTH(4), .NICK_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ex_dt(input logic [4:0] n);
        return 32'hE000_0000 | {27'd0, n};
    endfunction

    function automatic logic [31:0] ex_jpc(input logic [4:0] n);
        return 32'h0000_4000 + {25'd0, n, 2'b00};
    endfunction

    function automatic logic [31:0] slb_dt(input logic [4:0] n);
        return 32'h5A00_0000 | {27'd0, n};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_ex(input logic [4:0] n);
        sb.push_back('{nick: n, dt: ex_dt(n), ac: n[0], j_pc: ex_jpc(n), src: 1'b0});
    endtask

    task automatic exp_slb(input logic [4:0] n);
        sb.push_back('{nick: n, dt: slb_dt(n), ac: 1'b0, j_pc: 32'd0, src: 1'b1});
    endtask

    task automatic drive(input logic xe, input logic [4:0] xn,
                         input logic se, input logic [4:0] sn);
        bus.iEX_en    = xe;
        bus.iEX_nick  = xn;
        bus.iEX_dt    = ex_dt(xn);
        bus.iEX_ac    = xn[0];
        bus.iEX_j_pc  = ex_jpc(xn);
        bus.iSLB_en   = se;
        bus.iSLB_nick = sn;
        bus.iSLB_dt   = slb_dt(sn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        bus.rdy  = 1'b1;
        bus.iclr = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Monitor: one line per broadcast, compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.oCDB_en) begin
            mon_act = '{nick: bus.oCDB_nick, dt: bus.oCDB_dt, ac: bus.oCDB_ac,
                        j_pc: bus.oCDB_j_pc, src: bus.oCDB_src};
            $display("cdb: nick=%0d src=%0d dt=%08h ac=%0d j_pc=%08h",
                     mon_act.nick, mon_act.src, mon_act.dt, mon_act.ac, mon_act.j_pc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got nick=%0d src=%0d, required no broadcast",
                         mon_act.nick, mon_act.src);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL cdb_data: got nick=%0d src=%0d dt=%08h ac=%0d j_pc=%08h, required nick=%0d src=%0d dt=%08h ac=%0d j_pc=%08h",
                             mon_act.nick, mon_act.src, mon_act.dt, mon_act.ac, mon_act.j_pc,
                             mon_exp.nick, mon_exp.src, mon_exp.dt, mon_exp.ac, mon_exp.j_pc);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        bus.rdy  = 1'b1;
        bus.iclr = 1'b0;
        #2;

        // ---------------- reset / idle ----------------
        do_reset();
        chk("rst_en",       64'(bus.oCDB_en),   64'd0);
        chk("rst_nick",     64'(bus.oCDB_nick), 64'd0);
        chk("rst_dt",       64'(bus.oCDB_dt),   64'd0);
        chk("rst_ac",       64'(bus.oCDB_ac),   64'd0);
        chk("rst_jpc",      64'(bus.oCDB_j_pc), 64'd0);
        chk("rst_src",      64'(bus.oCDB_src),  64'd0);
        chk("rst_ex_full",  64'(bus.oEX_full),  64'd0);
        chk("rst_slb_full", 64'(bus.oSLB_full), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_en", 64'(bus.oCDB_en), 64'd0);
        end

        // ---------------- single EX result ----------------
        bus.iEX_en   = 1'b1;
        bus.iEX_nick = 5'd3;
        bus.iEX_dt   = 32'h11;
        bus.iEX_ac   = 1'b1;
        bus.iEX_j_pc = 32'h100;
        sb.push_back('{nick: 5'd3, dt: 32'h11, ac: 1'b1, j_pc: 32'h100, src: 1'b0});
        tick();                                   // edge k: accepted
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("single_no_bypass", 64'(bus.oCDB_en), 64'd0);
        tick();                                   // edge k+1: broadcast
        chk("single_en",   64'(bus.oCDB_en),   64'd1);
        chk("single_nick", 64'(bus.oCDB_nick), 64'd3);
        chk("single_dt",   64'(bus.oCDB_dt),   64'h11);
        chk("single_ac",   64'(bus.oCDB_ac),   64'd1);
        chk("single_jpc",  64'(bus.oCDB_j_pc), 64'h100);
        chk("single_src",  64'(bus.oCDB_src),  64'd0);
        tick();                                   // edge k+2: pulse over
        chk("single_pulse_end", 64'(bus.oCDB_en), 64'd0);

        // ---------------- contention from reset ----------------
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd5); exp_ex(5'd1); exp_slb(5'd5);
        tick();
        chk("cont_no_bypass", 64'(bus.oCDB_en), 64'd0);
        drive(1'b1, 5'd2, 1'b1, 5'd6); exp_ex(5'd2); exp_slb(5'd6);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("cont_en", 64'(bus.oCDB_en), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cont_en", 64'(bus.oCDB_en), 64'd1);
        end
        tick();
        chk("cont_end", 64'(bus.oCDB_en), 64'd0);

        // ---------------- full / freeze / wrap ----------------
        // EX and SLB both push each edge; SLB gets every other grant so it fills.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'(k), 1'b1, 5'(15 + k));
            exp_ex(5'(k));
            exp_slb(5'(15 + k));
            tick();
        end
        drive(1'b0, 5'd0, 1'b1, 5'd21); exp_slb(5'd21);
        tick();
        chk("full_slb_set", 64'(bus.oSLB_full), 64'd1);
        chk("full_ex_clr",  64'(bus.oEX_full),  64'd0);
        // Freeze with a 5th SLB entry offered: nothing moves.
        drive(1'b0, 5'd0, 1'b1, 5'd22);
        bus.rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("freeze_en",   64'(bus.oCDB_en),   64'd0);
            chk("freeze_full", 64'(bus.oSLB_full), 64'd1);
        end
        // Enabled again: SLB head granted, but the full FIFO still refuses 22.
        bus.rdy = 1'b1;
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("full_grant_en",   64'(bus.oCDB_en),   64'd1);
        chk("full_grant_nick", 64'(bus.oCDB_nick), 64'd18);
        chk("full_slb_clr",    64'(bus.oSLB_full), 64'd0);
        repeat (6) tick();
        // Refill SLB alone so its pointers wrap again.
        for (int n = 24; n < 30; n++) begin
            drive(1'b0, 5'd0, 1'b1, 5'(n));
            exp_slb(5'(n));
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) tick();
        chk("wrap_drained", 64'(sb.size()), 64'd0);

        // ---------------- flush ----------------
        do_reset();
        drive(1'b1, 5'd10, 1'b1, 5'd20); exp_ex(5'd10); exp_slb(5'd20); tick();
        drive(1'b1, 5'd11, 1'b1, 5'd21); exp_ex(5'd11); exp_slb(5'd21); tick();
        drive(1'b1, 5'd12, 1'b0, 5'd0); tick();
        drive(1'b1, 5'd13, 1'b0, 5'd0); tick();
        drive(1'b1, 5'd14, 1'b0, 5'd0); tick();
        chk("flush_pre_en", 64'(bus.oCDB_en), 64'd1);
        drive(1'b1, 5'd7, 1'b0, 5'd0);
        bus.iclr = 1'b1;
        tick();
        bus.iclr = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("flush_en",       64'(bus.oCDB_en),   64'd0);
        chk("flush_ex_full",  64'(bus.oEX_full),  64'd0);
        chk("flush_slb_full", 64'(bus.oSLB_full), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", 64'(bus.oCDB_en), 64'd0);
        end
        // Fresh entries come out first, proving the FIFOs were emptied.
        drive(1'b1, 5'd8, 1'b1, 5'd9); exp_ex(5'd8); exp_slb(5'd9);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("post_flush_idle", 64'(bus.oCDB_en), 64'd0);
        tick();
        chk("post_flush_first", 64'(bus.oCDB_nick), 64'd8);
        tick();
        chk("post_flush_second", 64'(bus.oCDB_nick), 64'd9);
        tick();
        chk("post_flush_end", 64'(bus.oCDB_en), 64'd0);

        // ---------------- async reset mid-broadcast ----------------
        drive(1'b1, 5'd12, 1'b0, 5'd0); exp_ex(5'd12); tick();
        drive(1'b1, 5'd13, 1'b0, 5'd0); tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        chk("arst_pre_en",   64'(bus.oCDB_en),   64'd1);
        chk("arst_pre_nick", 64'(bus.oCDB_nick), 64'd12);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_en",   64'(bus.oCDB_en),   64'd0);
        chk("arst_nick", 64'(bus.oCDB_nick), 64'd0);
        chk("arst_dt",   64'(bus.oCDB_dt),   64'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_lost", 64'(bus.oCDB_en), 64'd0);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
